mem_dump_reader: RTL and testbench

Read-side sequencer for the flip-flop storage blocks: on a start command it walks a contiguous address range of a synchronous-read memory, fetches each word and presents it on a valid/ready output stream, flagging the final word. It sits between a register bank built from `d_flip_flop` cells (the writer side, driven by `st`/`d`) and any consumer that needs the stored contents streamed back out, such as a debug dump or bus bridge.

---
 rtl/mem_dump_reader.sv | 150 +++++++++++++++
 tb/tb_mem_dump_reader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_reader.sv
// ============================================================================
// mem_dump_reader : streams a contiguous range of a sync-read memory out over
// a valid/ready port. Option macro: MEM_DUMP_READER_CHECKSUM_EN (XOR trailer).
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_dump_reader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

`ifdef MEM_DUMP_READER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_SEND  = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_SEND  = 3'd3,
        S_DONE  = 3'd5
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [ADDR_W:0]     rem_q,   rem_d;
    logic [DATA_W-1:0]   data_q,  data_d;
`ifdef MEM_DUMP_READER_CHECKSUM_EN
    logic [DATA_W-1:0]   csum_q,  csum_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
`ifdef MEM_DUMP_READER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
`ifdef MEM_DUMP_READER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
`ifdef MEM_DUMP_READER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = count;
`ifdef MEM_DUMP_READER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = (count != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                data_d  = mem_rdata;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    // Address wraps naturally at 2^ADDR_W.
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - (ADDR_W+1)'(1);
`ifdef MEM_DUMP_READER_CHECKSUM_EN
                    csum_d = csum_q ^ data_q;
                    if (rem_q == (ADDR_W+1)'(1)) state_d = S_CSUM;
                    else                         state_d = S_FETCH;
`else
                    if (rem_q == (ADDR_W+1)'(1)) state_d = S_DONE;
                    else                         state_d = S_FETCH;
`endif
                end
            end
`ifdef MEM_DUMP_READER_CHECKSUM_EN
            S_CSUM: begin
                if (out_ready) state_d = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd    = (state_q == S_FETCH);
        mem_addr  = mem_rd ? addr_q : '0;
        busy      = (state_q != S_IDLE) && (state_q != S_DONE);
        done      = (state_q == S_DONE);
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        if (state_q == S_SEND) begin
            out_valid = 1'b1;
            out_data  = data_q;
`ifndef MEM_DUMP_READER_CHECKSUM_EN
            out_last  = (rem_q == (ADDR_W+1)'(1));
`endif
        end
`ifdef MEM_DUMP_READER_CHECKSUM_EN
        if (state_q == S_CSUM) begin
            out_valid = 1'b1;
            out_data  = csum_q;
            out_last  = 1'b1;
        end
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_dump_reader.sv
// ============================================================================
// tb_mem_dump_reader : randomized and directed dumps checked against a
// queue-based model of the expected memory stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_dump_reader;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
`ifdef MEM_DUMP_READER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    mem_dump_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [DEPTH];
    initial mem_rdata = '0;
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_dump(input int b, input int c, input int rdy_pct,
                            input bit stall2, input bit midstart);
        logic [DATA_W-1:0] exp_d[$];
        bit                exp_l[$];
        int                exp_a[$];
        logic [DATA_W-1:0] got_d[$];
        bit                got_l[$];
        logic [DATA_W-1:0] acc, prev_d;
        bit                prev_l, prev_hold;
        bit                addr_ok, hold_ok, busy_ok;
        int                rd_cnt, first_v, done_at, stall_left, a, nw;
        logic [31:0]       bv, cv;

        acc = '0; prev_d = '0; prev_l = 1'b0; prev_hold = 1'b0;
        addr_ok = 1'b1; hold_ok = 1'b1; busy_ok = 1'b1;
        rd_cnt = 0; first_v = -1; done_at = -1;
        stall_left = stall2 ? 5 : 0;
        bv = b; cv = c;
        for (int i = 0; i < c; i++) begin
            a = (b + i) % DEPTH;
            exp_a.push_back(a);
            exp_d.push_back(mem[a]);
            exp_l.push_back(!CSUM_EN && (i == c - 1));
            acc ^= mem[a];
        end
        if (CSUM_EN && c > 0) begin
            exp_d.push_back(acc);
            exp_l.push_back(1'b1);
        end

        @(negedge clk);
        start = 1'b1; base_addr = bv[ADDR_W-1:0]; count = cv[ADDR_W:0];
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 400; n++) begin
            out_ready = ($urandom_range(99) < rdy_pct);
            if (stall_left > 0 && out_valid && got_d.size() == 1) begin
                out_ready = 1'b0;
                stall_left--;
            end
            start = midstart && (n == 3);
            if (start) begin
                base_addr = ADDR_W'($urandom);
                count     = (ADDR_W+1)'($urandom_range(1, DEPTH));
            end
            if (mem_rd) begin
                if (rd_cnt >= exp_a.size() || int'(mem_addr) != exp_a[rd_cnt]) addr_ok = 1'b0;
                rd_cnt++;
            end
            if (out_valid && first_v < 0) first_v = n;
            if (prev_hold && (!out_valid || out_data !== prev_d || out_last !== prev_l))
                hold_ok = 1'b0;
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
                prev_hold = 1'b0;
            end else begin
                prev_hold = out_valid;
                prev_d    = out_data;
                prev_l    = out_last;
            end
            if (done) begin
                if (busy) busy_ok = 1'b0;
                done_at = n;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;

        check_val($sformatf("done_seen b=%0d c=%0d", b, c), done_at >= 0, 1);
        check_val($sformatf("words b=%0d c=%0d", b, c), got_d.size(), exp_d.size());
        nw = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < nw; i++) begin
            check_val($sformatf("data[%0d] b=%0d c=%0d", i, b, c), got_d[i], exp_d[i]);
            check_val($sformatf("last[%0d] b=%0d c=%0d", i, b, c), got_l[i], exp_l[i]);
        end
        check_val($sformatf("rd_cnt b=%0d c=%0d", b, c), rd_cnt, c);
        check_val($sformatf("rd_addr b=%0d c=%0d", b, c), addr_ok, 1);
        check_val($sformatf("hold b=%0d c=%0d", b, c), hold_ok, 1);
        check_val($sformatf("busy b=%0d c=%0d", b, c), busy_ok, 1);
        if (c > 0)
            check_val($sformatf("first_latency c=%0d", c), first_v, 2);
        if (rdy_pct == 100 && !stall2)
            check_val($sformatf("done_cycle c=%0d", c), done_at,
                      3 * c + ((CSUM_EN && c > 0) ? 1 : 0));
        @(negedge clk);
        check_val("idle_after", {busy, done, out_valid, mem_rd}, 4'b0000);
    endtask

    initial begin
        bit held_idle;
        bit seen_v;
        rst_n = 1'b1; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i + 8'h10);
        #2 rst_n = 1'b0;
        #1;
        check_val("reset_outputs", {mem_rd, mem_addr, out_valid, out_data, out_last, busy, done}, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset while a word is waiting in SEND.
        @(negedge clk);
        start = 1'b1; base_addr = 4'd0; count = 5'd8; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        seen_v = 1'b0;
        for (int n = 0; n < 10 && !seen_v; n++) begin
            if (out_valid) seen_v = 1'b1;
            else @(negedge clk);
        end
        check_val("mid_reset_in_send", seen_v, 1);
        rst_n = 1'b0;
        #1;
        check_val("mid_reset_outputs", {mem_rd, mem_addr, out_valid, out_data, out_last, busy, done}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        held_idle = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (busy || done || mem_rd || out_valid) held_idle = 1'b0;
        end
        check_val("idle_after_reset", held_idle, 1);

        run_dump(2, 3, 100, 1'b0, 1'b0);
        run_dump(14, 4, 100, 1'b0, 1'b0);
        run_dump(0, 4, 100, 1'b1, 1'b0);
        run_dump(5, 0, 100, 1'b0, 1'b0);
        run_dump(3, 6, 100, 1'b0, 1'b1);
        run_dump(7, 16, 100, 1'b0, 1'b0);
`ifdef MEM_DUMP_READER_CHECKSUM_EN
        mem[0] = 8'hA5; mem[1] = 8'h0F; mem[2] = 8'h33;
        run_dump(0, 3, 100, 1'b0, 1'b0);
`endif
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
            run_dump($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH),
                     $urandom_range(30, 100), 1'b0, (t % 4) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
